// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST sequencers: state encoding,
// default watchdog limit and the polarity of the BIST status line.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Default number of cycles a run may take before it is declared hung.
  localparam int unsigned TO_CYC_DEFAULT = 1023;

  // Value of bist_status that means the memory test passed.
  localparam logic BIST_PASS = 1'b1;

endpackage : bist_pkg

// File: rtl/bist_watchdog.sv
// Cycle watchdog for BIST runs. Counts while enabled, stops at the limit
// and flags expiry; a clear has priority over counting.
module bist_watchdog #(
  parameter int unsigned TO_W   = 10,
  parameter int unsigned TO_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TO_CYC);
  localparam logic [TO_W-1:0] ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and park at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule : bist_watchdog

// File: rtl/bist_launcher.sv
// Host-facing BIST sequencer: launches a requested number of BIST runs,
// waits for each completion under a watchdog, tallies pass/fail and hands
// one aggregate result back through a valid/ack handshake.
module bist_launcher
  import bist_pkg::*;
#(
  parameter int unsigned RUN_W  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned TO_CYC = TO_CYC_DEFAULT,
  parameter int unsigned TO_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [RUN_W-1:0] runs,
  input  logic             ack,
  output logic             busy,
  output logic             bist_start,
  input  logic             bist_status,
  input  logic             bist_done,
  output logic             result_valid,
  output logic             result_pass,
  output logic             timeout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating increment for the result counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_e           state_q,   state_d;
  logic [RUN_W-1:0] target_q,  target_d;
  logic [RUN_W-1:0] run_idx_q, run_idx_d;
  logic [CNT_W-1:0] pass_q,    pass_d;
  logic [CNT_W-1:0] fail_q,    fail_d;
  logic             to_q,      to_d;
  logic             start_q,   start_d;
  logic             valid_q,   valid_d;
  logic             rpass_q,   rpass_d;
  logic             busy_q,    busy_d;
  logic             run_end_s;
  logic             wd_clr_s;
  logic             wd_en_s;
  logic             wd_expired_s;

  // The watchdog restarts on every state change and after every finished
  // run (a timed-out DRAIN may re-enter DRAIN for the next run).
  assign wd_clr_s = (state_d != state_q) || run_end_s;
  assign wd_en_s  = (state_q == ST_DRAIN) || (state_q == ST_WAIT);

  bist_watchdog #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr_s),
    .en_i      (wd_en_s),
    .expired_o (wd_expired_s)
  );

  // Next-state, counter updates and registered-output values.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    run_idx_d = run_idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    to_d      = to_q;
    run_end_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          target_d  = (runs == '0) ? RUN_ONE : runs;
          run_idx_d = '0;
          pass_d    = '0;
          fail_d    = '0;
          to_d      = 1'b0;
          state_d   = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Never launch while a stale done from an earlier run is visible.
        if (!bist_done) begin
          state_d = ST_LAUNCH;
        end else if (wd_expired_s) begin
          to_d      = 1'b1;
          fail_d    = sat_inc(fail_q);
          run_end_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the expiry cycle still counts as a real completion.
        if (bist_done) begin
          if (bist_status == BIST_PASS) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_d = sat_inc(fail_q);
          end
          run_end_s = 1'b1;
        end else if (wd_expired_s) begin
          to_d      = 1'b1;
          fail_d    = sat_inc(fail_q);
          run_end_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_REPORT: begin
        if (ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (run_end_s) begin
      run_idx_d = run_idx_q + RUN_ONE;
      state_d   = (run_idx_d < target_q) ? ST_DRAIN : ST_REPORT;
    end else begin
      run_idx_d = run_idx_d;
    end

    start_d = (state_d == ST_LAUNCH);
    valid_d = (state_d == ST_REPORT);
    busy_d  = (state_d != ST_IDLE);
    rpass_d = (state_d == ST_REPORT) && (fail_d == '0) && !to_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      run_idx_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      to_q      <= 1'b0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      rpass_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      run_idx_q <= run_idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      rpass_q   <= rpass_d;
      busy_q    <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign bist_start   = start_q;
  assign result_valid = valid_q;
  assign result_pass  = rpass_q;
  assign timeout      = to_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;

endmodule : bist_launcher

// File: tb/tb_bist_launcher.sv
// Scoreboard bench for bist_launcher: a BIST responder follows per-run
// plans (latency, status, done hold time), a reference model turns the
// plans into the expected aggregate, and a monitor compares each result.
module tb_bist_launcher;

  localparam int RUN_W  = 4;
  localparam int CNT_W  = 8;
  localparam int TO_CYC = 16;
  localparam int TO_W   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             ack = 1'b0;
  logic [RUN_W-1:0] runs = '0;
  logic             busy, bist_start, result_valid, result_pass, timeout;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic             bist_done, bist_status;
  logic             resp_done = 1'b0;
  logic             resp_status = 1'b0;
  logic             stale_done = 1'b0;

  assign bist_done   = resp_done | stale_done;
  assign bist_status = resp_status;

  bist_launcher #(
    .RUN_W (RUN_W), .CNT_W (CNT_W), .TO_CYC (TO_CYC), .TO_W (TO_W)
  ) dut (
    .clk (clk), .rst (rst), .req (req), .runs (runs), .ack (ack),
    .busy (busy), .bist_start (bist_start), .bist_status (bist_status),
    .bist_done (bist_done), .result_valid (result_valid),
    .result_pass (result_pass), .timeout (timeout),
    .pass_cnt (pass_cnt), .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  // lat: cycles after the start cycle at which done is seen (0 = never).
  typedef struct { int lat; bit st; int hold; } plan_t;
  typedef struct { int pass; int fail; bit to; bit rp; int starts; } exp_t;

  plan_t plan_q[$];
  plan_t pl[$];
  exp_t  exp_q[$];
  exp_t  last_exp;
  exp_t  mon_e;
  plan_t cur;
  int    checks = 0;
  int    errors = 0;
  int    start_seen = 0;
  int    start_base = 0;
  int    cd = -1;
  int    hc = 0;
  logic  rv_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  function automatic plan_t mk(input int lat, input bit st, input int hold);
    plan_t p;
    p.lat = lat; p.st = st; p.hold = hold;
    return p;
  endfunction

  // Reference: a run counts by its status if done arrives within the
  // allowed window (lat <= TO_CYC+1), otherwise it is a timed-out failure.
  function automatic exp_t model(input plan_t p[$]);
    exp_t e;
    e.pass = 0; e.fail = 0; e.to = 1'b0; e.starts = p.size();
    foreach (p[i]) begin
      if (p[i].lat >= 1 && p[i].lat <= TO_CYC + 1) begin
        if (p[i].st) e.pass++; else e.fail++;
      end else begin
        e.fail++;
        e.to = 1'b1;
      end
    end
    e.rp = (e.fail == 0) && !e.to;
    return e;
  endfunction

  // BIST responder: on each start pop a plan, raise done after lat cycles
  // and keep it high for hold cycles; status is wrong while done is low.
  always @(negedge clk) begin
    if (rst) begin
      cd = -1; hc = 0; resp_done = 1'b0;
    end else begin
      if (hc > 0) begin
        hc--;
        if (hc == 0) begin resp_done = 1'b0; resp_status = ~resp_status; end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          resp_done = 1'b1; resp_status = cur.st; hc = cur.hold; cd = -1;
        end
      end
      if (bist_start) begin
        start_seen++;
        if (plan_q.size() > 0) begin
          cur = plan_q.pop_front();
          resp_status = ~cur.st;
          if (cur.lat > 0) cd = cur.lat;
        end
      end
    end
  end

  // Monitor: compare each newly presented result against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      rv_prev = 1'b0;
    end else begin
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=valid required=none");
        end else begin
          mon_e = exp_q.pop_front();
          check("pass_cnt", int'(pass_cnt), mon_e.pass);
          check("fail_cnt", int'(fail_cnt), mon_e.fail);
          check("timeout", int'(timeout), int'(mon_e.to));
          check("result_pass", int'(result_pass), int'(mon_e.rp));
          check("start_pulses", start_seen - start_base, mon_e.starts);
        end
      end
      rv_prev = result_valid;
    end
  end

  task automatic wait_done_low();
    int n = 0;
    while (bist_done && n < 20) begin @(posedge clk); #1; n++; end
    check("done_low_before_req", int'(bist_done), 0);
  endtask

  // Queue plans and expectation, then issue one request. With chk_lat the
  // two-cycle req-to-start latency is verified; returns in the LAUNCH cycle.
  task automatic issue(input logic [RUN_W-1:0] r, input bit chk_lat);
    last_exp = model(pl);
    foreach (pl[i]) plan_q.push_back(pl[i]);
    exp_q.push_back(last_exp);
    start_base = start_seen;
    req = 1'b1; runs = r;
    @(posedge clk); #1;
    req = 1'b0; runs = RUN_W'($urandom);
    check("busy_after_req", int'(busy), 1);
    check("no_start_in_drain", int'(bist_start), 0);
    if (chk_lat) begin
      @(posedge clk); #1;
      check("start_latency", int'(bist_start), 1);
    end
  endtask

  task automatic wait_report(output int n);
    n = 0;
    while (!result_valid && n < 2000) begin @(posedge clk); #1; n++; end
    if (!result_valid) begin
      checks++; errors++;
      $display("FAIL report_wait actual=no_valid required=valid");
    end
  endtask

  task automatic finish_seq(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", int'(result_valid), 1);
      check("hold_pass_cnt", int'(pass_cnt), last_exp.pass);
      check("hold_fail_cnt", int'(fail_cnt), last_exp.fail);
      check("hold_result_pass", int'(result_pass), int'(last_exp.rp));
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("valid_drop_after_ack", int'(result_valid), 0);
    check("idle_after_ack", int'(busy), 0);
  endtask

  initial begin
    int n;
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(bist_start), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_pass_cnt", int'(pass_cnt), 0);
    check("rst_fail_cnt", int'(fail_cnt), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single pass, runs=0 means one run.
    pl.delete(); pl.push_back(mk(10, 1'b1, 1));
    issue(4'd0, 1'b1); wait_report(n); finish_seq(2);

    // Mixed 1/0/1 with a level done on the middle run.
    wait_done_low();
    pl.delete();
    pl.push_back(mk(10, 1'b1, 1)); pl.push_back(mk(7, 1'b0, 3)); pl.push_back(mk(4, 1'b1, 1));
    issue(4'd3, 1'b1); wait_report(n); finish_seq(0);

    // Timeout: no done ever; REPORT after TO_CYC+2 edges from the start cycle.
    wait_done_low();
    pl.delete(); pl.push_back(mk(0, 1'b1, 1));
    issue(4'd1, 1'b1); wait_report(n);
    check("timeout_report_latency", n, TO_CYC + 2);
    finish_seq(0);

    // Done on the exact expiry cycle wins; one cycle later is a timeout.
    pl.delete(); pl.push_back(mk(TO_CYC + 1, 1'b1, 1));
    issue(4'd0, 1'b1); wait_report(n); finish_seq(0);
    wait_done_low();
    pl.delete(); pl.push_back(mk(TO_CYC + 2, 1'b1, 1));
    issue(4'd0, 1'b1); wait_report(n); finish_seq(0);

    // Stale done held across the request.
    wait_done_low();
    stale_done = 1'b1;
    pl.delete(); pl.push_back(mk(6, 1'b1, 1));
    issue(4'd1, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      check("stale_no_start", int'(bist_start), 0);
    end
    stale_done = 1'b0;
    wait_report(n); finish_seq(0);

    // Reset in the middle of run 2 of 3.
    wait_done_low();
    for (int i = 0; i < 3; i++) plan_q.push_back(mk(6, 1'b1, 1));
    base = start_seen;
    req = 1'b1; runs = 4'd3;
    @(posedge clk); #1; req = 1'b0;
    n = 0;
    while ((start_seen - base) < 2 && n < 200) begin @(posedge clk); #1; n++; end
    check("reset_test_second_start", start_seen - base, 2);
    @(posedge clk); #1;
    check("pre_reset_pass_cnt", int'(pass_cnt), 1);
    rst = 1'b1; #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_start", int'(bist_start), 0);
    check("midrst_pass_cnt", int'(pass_cnt), 0);
    check("midrst_fail_cnt", int'(fail_cnt), 0);
    check("midrst_timeout", int'(timeout), 0);
    repeat (3) @(posedge clk);
    #1; plan_q.delete(); base = start_seen; rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("no_start_after_reset", start_seen - base, 0);
    pl.delete(); pl.push_back(mk(5, 1'b1, 1));
    issue(4'd0, 1'b1); wait_report(n);

    // Handshake: long ack hold, then ack with req in the same cycle.
    finish_seq(20);
    wait_done_low();
    pl.delete(); pl.push_back(mk(3, 1'b0, 1)); pl.push_back(mk(3, 1'b1, 1));
    issue(4'd2, 1'b1); wait_report(n);
    @(posedge clk); #1;
    ack = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; req = 1'b0;
    check("ack_req_valid_drop", int'(result_valid), 0);
    check("ack_req_ignored", int'(busy), 0);
    @(posedge clk); #1;
    check("ack_req_still_idle", int'(busy), 0);
    check("idle_keeps_fail_cnt", int'(fail_cnt), 1);

    // Randomized sequences.
    for (int s = 0; s < 25; s++) begin
      logic [RUN_W-1:0] r;
      int nr;
      r  = RUN_W'($urandom_range(0, 5));
      nr = (r == '0) ? 1 : int'(r);
      pl.delete();
      for (int k = 0; k < nr; k++) begin
        int sel, lat, hold;
        bit st;
        sel = $urandom_range(0, 9);
        case (sel)
          0: lat = 0;
          1: lat = TO_CYC + 1;
          2: lat = TO_CYC + 2;
          default: lat = $urandom_range(1, 12);
        endcase
        st   = ($urandom_range(0, 3) != 0);
        hold = ($urandom_range(0, 1) != 0) ? 1 : $urandom_range(2, 4);
        pl.push_back(mk(lat, st, hold));
      end
      wait_done_low();
      issue(r, 1'b1);
      wait_report(n);
      finish_seq($urandom_range(0, 3));
    end

    check("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule : tb_bist_launcher

// File: doc/bist_launcher.md
Name: bist_launcher

Overview:
- Upstream sequencer for the memory BIST instance, and the consumer of its results.
- Takes a host request, then pulses the BIST start input a programmed number of times.
- Waits for done after each run and samples status. Guards every run with a timeout watchdog.
- Accumulates pass/fail counts and presents one aggregate result to the host through a valid/ack handshake.

Parameters:
- RUN_W, 4, width of the requested run count (up to 2^RUN_W-1 runs per request).
- CNT_W, 8, width of the pass and fail counters (saturating).
- TO_CYC, 1023, maximum cycles to wait for bist_done in one run before declaring timeout.
- TO_W, 10, width of the watchdog counter; must satisfy 2^TO_W > TO_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  host request. Sampled only in IDLE. Level; a high sample starts a sequence.
- runs  in  RUN_W  number of BIST runs. Latched when req is accepted. 0 means one run.
- ack  in  1  host acknowledge of the result. Consumed only in REPORT.
- busy  out  1  high in every state except IDLE.
- bist_start  out  1  one-cycle start pulse to the BIST.
- bist_status  in  1  BIST result, valid while bist_done is high. 1 = pass, 0 = fail.
- bist_done  in  1  BIST completion (level or pulse; both accepted).
- result_valid  out  1  aggregate result available (REPORT state).
- result_pass  out  1  1 when every run passed and no timeout occurred.
- timeout  out  1  sticky for the sequence; set if any run timed out.
- pass_cnt  out  CNT_W  runs that completed with status=1.
- fail_cnt  out  CNT_W  runs that completed with status=0, plus runs that timed out.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0. Reset mid-sequence aborts immediately; no further bist_start is issued.
- States: IDLE, DRAIN, LAUNCH, WAIT, REPORT.
- IDLE:
  - On req=1, latch target = (runs==0 ? 1 : runs), clear pass_cnt, fail_cnt, timeout, run index and watchdog, then go to DRAIN.
  - result_valid stays 0.
- DRAIN:
  - Waits until bist_done=0, so a stale done from a previous run is never counted.
  - Watchdog counts every cycle. If it reaches TO_CYC, set timeout, increment fail_cnt, increment run index, then follow the same next-run rule as WAIT.
  - When bist_done=0, clear the watchdog and go to LAUNCH.
- LAUNCH:
  - bist_start=1 for exactly this one cycle (registered output, high on the cycle the state is LAUNCH). Next state WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On bist_done=1: sample bist_status, increment pass_cnt or fail_cnt, increment run index. Go to DRAIN if run index < target, else REPORT.
  - If the watchdog reaches TO_CYC with bist_done still 0: set timeout, increment fail_cnt, increment run index, same next-state rule.
  - If done and watchdog expiry coincide, done wins: the run is counted from bist_status and is not a timeout.
- REPORT:
  - result_valid=1.
  - result_pass = (fail_cnt==0) && !timeout, stable while valid.
  - Counters hold. On ack=1, go to IDLE next cycle; result_valid drops then.
  - Counters and timeout keep their values in IDLE until the next accepted req.
- Counters: pass_cnt and fail_cnt saturate at 2^CNT_W-1. Run index is RUN_W bits and never wraps, because the maximum target is 2^RUN_W-1.
- Latency: req high in IDLE → DRAIN next cycle. With bist_done low, bist_start asserts 2 cycles after req is sampled.
- Changes to req or runs outside IDLE are ignored. ack outside REPORT is ignored.

Decomposition:
- Shared package (bist_pkg): state encoding constants (IDLE/DRAIN/LAUNCH/WAIT/REPORT), default TO_CYC, and the status polarity constant BIST_PASS=1.
- One sub-module is natural: bist_watchdog. It is a TO_W-bit counter with clear/enable inputs and an expired output, reusable by other BIST sequencers.
- The FSM and counters stay in bist_launcher.

Test Plan:
- Single pass: runs=0, req=1. BIST model returns done=1, status=1 ten cycles after start → exactly one bist_start pulse; REPORT with pass_cnt=1, fail_cnt=0, result_pass=1, timeout=0.
- Mixed runs: runs=3; model returns status 1, 0, 1 → three start pulses, each preceded by done=0; pass_cnt=2, fail_cnt=1, result_pass=0.
- Timeout: runs=1, TO_CYC=16, model never asserts done → timeout=1 at watchdog expiry, fail_cnt=1, result_pass=0, REPORT entered; no second start.
- Stale done: hold bist_done=1 when req arrives, release after 5 cycles → no bist_start until done is low. Then a normal pass gives pass_cnt=1.
- Coincident done and expiry: done=1, status=1 on the exact expiry cycle → pass_cnt=1, timeout=0.
- Reset mid-WAIT: assert rst during run 2 of 3 → all outputs 0 immediately, no further bist_start. A fresh req afterwards runs cleanly from a pass_cnt/fail_cnt of 0.
- Handshake: hold ack=0 in REPORT for 20 cycles → result_valid and counters stable. ack=1 → IDLE next cycle; req in that same cycle is ignored until IDLE.
